// File: rtl/umich_select_arbiter.sv
// umich_select_arbiter: round-robin arbiter driving a one-hot select mux that
// shares one output channel among NUM_REQ packet sources. A grant is held
// from the first beat until the last beat is accepted, then the priority
// pointer moves past the winner. Optional idle-grant watchdog is compiled in
// with `define UMICH_ARB_TIMEOUT_EN.
module umich_select_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clocked_on,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      err_timeout
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [PW-1:0]      win, win_nxt, ptr, ptr_nxt, pick_idx, win_inc;
    logic               pick_any, xfer, tmo_hit;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_param_check
            $error("umich_select_arbiter: parameter out of range");
        end
    endgenerate

    // Circular search for the first requesting lane starting at ptr; the
    // loop runs from lowest to highest priority so the last hit wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick_any = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx -= NUM_REQ;
            if (req_valid[idx]) begin
                pick_any = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    // Pointer value after the current winner, wrapping at NUM_REQ-1.
    always_comb begin
        win_inc = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

`ifdef UMICH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt;
    logic          err_q;

    assign tmo_hit     = (state == BUSY) && (idle_cnt == CW'(TIMEOUT));
    assign err_timeout = err_q;

    // Watchdog: counts granted cycles with no beat offered; any transfer or
    // a fresh grant restarts it. A backpressure stall (valid high) never counts.
    always_ff @(posedge clocked_on or negedge clear) begin
        if (!clear) begin
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state == IDLE || xfer || tmo_hit) idle_cnt <= '0;
            else if (!out_valid)                  idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State, grant, winner and priority pointer registers.
    always_ff @(posedge clocked_on or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            gnt   <= '0;
            win   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            win   <= win_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next state: grant in IDLE, release after the last beat (or watchdog).
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        win_nxt   = win;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BUSY;
                    win_nxt   = pick_idx;
                    gnt_nxt   = NUM_REQ'(1) << pick_idx;
                end
            end
            BUSY: begin
                if (tmo_hit || (xfer && out_last)) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = win_inc;
                end
            end
            default: ;
        endcase
    end

    // One-hot AND-OR mux of the granted lane; gnt is zero in IDLE so the
    // channel shows no valid beat there.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            out_data = out_data | ({DATA_W{gnt[k]}} & req_data[k*DATA_W +: DATA_W]);
            out_last = out_last | (gnt[k] & req_last[k]);
        end
        out_valid = |(req_valid & gnt);
        req_ready = gnt & {NUM_REQ{out_ready}};
        xfer      = out_valid & out_ready;
    end

endmodule
